fft_stage_transpose: RTL

- Sits between stage-1 and stage-2 passes of the 16-point radix-4 butterfly.
- Accepts the four 136-bit stage-1 outputs of one frame and re-emits them transposed as stage-2 input words, tagged with the stage-2 rotation code.
- Ping-pong double buffering lets one frame fill while the previous frame drains, so streaming is continuous.

---
 rtl/fft_pkg.sv | 15 +
 rtl/fft_transpose_bank.sv | 34 +++
 rtl/fft_stage_transpose.sv | 107 ++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared sizes and lane helpers for the radix-4 stage-1 to stage-2 transpose buffer.
package fft_pkg;

    localparam int LANE_W = 34;
    localparam int NLANE  = 4;
    localparam int WORD_W = LANE_W * NLANE;

    localparam logic [2:0] ROT_STAGE2_BASE = 3'b100;

    function automatic logic [LANE_W-1:0] lane_sel(input logic [WORD_W-1:0] word,
                                                   input logic [1:0]        k);
        return word[LANE_W*k +: LANE_W];
    endfunction

endpackage

// File: rtl/fft_transpose_bank.sv
// One 4-word register bank; the read port gathers lane `lane` of every stored word.
module fft_transpose_bank
    import fft_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [1:0]        waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [1:0]        lane,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [NLANE];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NLANE; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Output lane i comes from stored word i, so a column of the 4x4 lane matrix becomes a row.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < NLANE; i++) begin
            rdata[LANE_W*i +: LANE_W] = lane_sel(mem[i], lane);
        end
    end

endmodule

// File: rtl/fft_stage_transpose.sv
// Ping-pong transpose buffer between radix-4 stage 1 and stage 2.
// Optional frame-start checking is enabled with FFT_TRANSPOSE_FRAME_CHECK_EN.
module fft_stage_transpose
    import fft_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
`ifdef FFT_TRANSPOSE_FRAME_CHECK_EN
    input  logic              in_first,
    output logic              frame_err,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic [2:0]        out_rotation,
    output logic              out_last
);

    logic              wbank;
    logic              rbank;
    logic [1:0]        wcnt;
    logic [1:0]        rcnt;
    logic [1:0]        full;
    logic [1:0]        waddr;
    logic              wr_fire;
    logic              rd_fire;
    logic [WORD_W-1:0] rdata0;
    logic [WORD_W-1:0] rdata1;

    assign in_ready  = !full[wbank];
    assign out_valid = full[rbank];
    assign wr_fire   = in_valid && in_ready;
    assign rd_fire   = out_valid && out_ready;

`ifdef FFT_TRANSPOSE_FRAME_CHECK_EN
    // A frame marker always restarts the fill at word 0, dropping any partial frame.
    assign waddr = in_first ? 2'd0 : wcnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
        end else if (wr_fire && ((in_first && wcnt != 2'd0) || (!in_first && wcnt == 2'd0))) begin
            frame_err <= 1'b1;
        end
    end
`else
    assign waddr = wcnt;
`endif

    // Writer and reader never own the same bank at once, so set and clear of full never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbank <= 1'b0;
            rbank <= 1'b0;
            wcnt  <= 2'd0;
            rcnt  <= 2'd0;
            full  <= 2'b00;
        end else begin
            if (wr_fire) begin
                if (waddr == 2'd3) begin
                    full[wbank] <= 1'b1;
                    wbank       <= !wbank;
                    wcnt        <= 2'd0;
                end else begin
                    wcnt <= waddr + 2'd1;
                end
            end
            if (rd_fire) begin
                if (rcnt == 2'd3) begin
                    full[rbank] <= 1'b0;
                    rbank       <= !rbank;
                    rcnt        <= 2'd0;
                end else begin
                    rcnt <= rcnt + 2'd1;
                end
            end
        end
    end

    fft_transpose_bank u_bank0 (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_fire && !wbank),
        .waddr (waddr),
        .wdata (in_data),
        .lane  (rcnt),
        .rdata (rdata0)
    );

    fft_transpose_bank u_bank1 (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_fire && wbank),
        .waddr (waddr),
        .wdata (in_data),
        .lane  (rcnt),
        .rdata (rdata1)
    );

    assign out_data     = rbank ? rdata1 : rdata0;
    assign out_rotation = ROT_STAGE2_BASE | {1'b0, rcnt};
    assign out_last     = (rcnt == 2'd3);

endmodule
